id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  Decode/execute boundary register of the 5-stage MIPS pipeline. Latches the 13-bit control
//  word from the pipeline controller, plus PC, operands, immediate and destination register.
//  Detects load-use hazards and inserts one bubble per hazard. Stalls ID for that bubble.
//  Honours a downstream hold and a branch/jump flush.
// PARAMETERS
//  XLEN   32  datapath width (PC, operands, immediate)
//  CNT_W  32  width of the load-use bubble counter
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      synchronous, active-high reset
//  id_valid_i   in   1      ID holds a real instruction
//  id_ctrl_i    in   13     control word from controller (layout: ctrl_t)
//  id_instr_i   in   32     raw instruction (rs[25:21] rt[20:16] rd[15:11] shamt[10:6] imm[15:0])
//  id_pc_i      in   XLEN   PC+4 of the ID instruction
//  id_rs_val_i  in   XLEN   register-file read of rs
//  id_rt_val_i  in   XLEN   register-file read of rt
//  hold_i       in   1      downstream busy: freeze EX register
//  flush_i      in   1      branch/jump redirect: kill the ID instruction
//  id_stall_o   out  1      ID/IF must not advance this cycle (combinational)
//  ex_valid_o   out  1      EX register holds a real instruction
//  ex_ctrl_o    out  13     registered control word
//  ex_pc_o      out  XLEN   registered PC+4 (jal link value)
//  ex_a_o       out  XLEN   registered rs value
//  ex_b_o       out  XLEN   registered rt value
//  ex_imm_o     out  XLEN   extended immediate
//  ex_shamt_o   out  5      shift amount
//  ex_rs_o      out  5      rs index (for forwarding unit)
//  ex_rt_o      out  5      rt index (for forwarding unit)
//  ex_dst_o     out  5      write-back register; 0 = no write
//  bubble_cnt_o out  CNT_W  count of inserted load-use bubbles
// BEHAVIOUR
//  - ctrl_t fields [12:11] wb_sel, [10] sext, [9] link, [8] mem_to_reg, [7] shift, [6] alu_imm,
//    [5:2] alu_op, [1] mem_write, [0] mem_read.
//  - dst decode: wb_sel 2'b10 -> rd; 2'b11 -> rt; 2'b01 -> 5'd31; 2'b00 -> 0.
//  - imm: sext ? {{16{imm[15]}},imm} : {16'b0,imm}.
//  - Operand use: rs_used = !shift && !link. rt_used = !alu_imm || mem_write.
//    Index 0 is never a hazard.
//  - hazard = ex_valid_o && ex_ctrl_o.mem_read && ex_dst_o!=0 && id_valid_i &&
//    ((rs_used && rs==ex_dst_o) || (rt_used && rt==ex_dst_o)).
//  - id_stall_o = !flush_i && (hold_i || hazard).
//  - Per-edge priority: reset > flush_i > hold_i > hazard > load.
//    reset : all outputs 0, bubble_cnt_o 0.
//    flush : EX <= bubble (valid 0, ctrl 0, dst 0; other fields don't-care, driven 0).
//    hold  : every EX field keeps its value; counter unchanged.
//    hazard: EX <= bubble; bubble_cnt_o += 1, saturating at all-ones.
//            The load advances, so the next cycle reloads normally. Latency: exactly one bubble.
//    load  : EX <= decoded ID fields. valid = id_valid_i.
//            If !id_valid_i, ctrl and dst are forced to 0.
//  - flush_i with hazard: no bubble is counted and no stall is raised.
//  - hold_i with hazard: stall only; the bubble is inserted on the first non-hold cycle if the
//    hazard persists.
//  - Latency ID->EX is 1 cycle. Outputs change only on clk edges, except id_stall_o.
//  - Reset mid-operation discards the in-flight instruction. No residual stall follows reset.
// STRUCTURE
//  - pipeline_pkg: ctrl_t packed struct, WB_RD/WB_RT/WB_RA/WB_NONE constants, REG_RA = 5'd31,
//    bubble constant.
//  - One sub-module, hazard_detect (pure combinational: ID indices, ID ctrl, EX dst/ctrl -> hazard).
//  - The register, priority mux and counter stay in id_ex_stage.
// TESTING
//  - Reset: assert reset 2 cycles with random inputs.
//    -> all ex_* 0, bubble_cnt_o 0, id_stall_o 0 after release.
//  - Load-use: lw $8,0($9), then add $10,$8,$11 in ID.
//    -> id_stall_o 1 for one cycle; the next EX is a bubble; add enters one cycle later;
//       bubble_cnt_o = 1.
//  - No false hazard: lw $0 then use $0, or lw $8 then addi $9,$8-free / sll using rt != 8.
//    -> no stall, bubble_cnt_o unchanged.
//  - Flush vs hazard: same-cycle flush_i and hazard.
//    -> EX bubble, id_stall_o 0, counter unchanged.
//  - Hold: hold_i 3 cycles during a hazard.
//    -> EX frozen and stall held 3 cycles; then exactly one bubble is counted.
//  - Decode: jal at PC+4 = 0x400010.
//    -> ex_dst_o 31, ex_pc_o 0x400010.
//    andi imm 0x8000 -> ex_imm_o 0x00008000; addi imm 0x8000 -> 0xFFFF8000.

Source files
------------

// File: rtl/pipeline_pkg.sv
// ============================================================================
//  Module      : pipeline_pkg
//  Description : Shared types and constants for the ID/EX boundary of the
//                5-stage MIPS pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

    typedef struct packed {
        logic [1:0] wb_sel;
        logic       sext;
        logic       link;
        logic       mem_to_reg;
        logic       shift;
        logic       alu_imm;
        logic [3:0] alu_op;
        logic       mem_write;
        logic       mem_read;
    } ctrl_t;

    localparam int         CTRL_W  = $bits(ctrl_t);

    localparam logic [1:0] WB_NONE = 2'b00;
    localparam logic [1:0] WB_RA   = 2'b01;
    localparam logic [1:0] WB_RD   = 2'b10;
    localparam logic [1:0] WB_RT   = 2'b11;

    localparam logic [4:0] REG_RA  = 5'd31;

    localparam ctrl_t      CTRL_BUBBLE = '0;

    // Destination register selected by the write-back mode.
    function automatic logic [4:0] dst_decode(input logic [1:0] wb_sel,
                                              input logic [4:0] rt,
                                              input logic [4:0] rd);
        logic [4:0] dst;
        case (wb_sel)
            WB_RD:   dst = rd;
            WB_RT:   dst = rt;
            WB_RA:   dst = REG_RA;
            default: dst = 5'd0;
        endcase
        return dst;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// ============================================================================
//  Module      : hazard_detect
//  Description : Combinational load-use hazard check between the instruction
//                in ID and a load sitting in the EX register.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_detect (
    input  logic       id_valid_i,
    input  logic       id_shift_i,
    input  logic       id_link_i,
    input  logic       id_alu_imm_i,
    input  logic       id_mem_write_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       ex_valid_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_dst_i,
    output logic       hazard_o
);

    logic w_rs_used;
    logic w_rt_used;
    logic w_ex_load;

    // Shifts take their source from rt/shamt and jal has no register source;
    // stores read rt even though the ALU uses the immediate.
    assign w_rs_used = !id_shift_i && !id_link_i;
    assign w_rt_used = !id_alu_imm_i || id_mem_write_i;
    assign w_ex_load = ex_valid_i && ex_mem_read_i && (ex_dst_i != 5'd0);

    assign hazard_o = w_ex_load && id_valid_i &&
                      ((w_rs_used && (id_rs_i == ex_dst_i)) ||
                       (w_rt_used && (id_rt_i == ex_dst_i)));

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register with load-use bubble insertion,
//                downstream hold, branch flush and a bubble counter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic [31:0]       id_instr_i,
    input  logic [XLEN-1:0]   id_pc_i,
    input  logic [XLEN-1:0]   id_rs_val_i,
    input  logic [XLEN-1:0]   id_rt_val_i,
    input  logic              hold_i,
    input  logic              flush_i,
    output logic              id_stall_o,
    output logic              ex_valid_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic [XLEN-1:0]   ex_pc_o,
    output logic [XLEN-1:0]   ex_a_o,
    output logic [XLEN-1:0]   ex_b_o,
    output logic [XLEN-1:0]   ex_imm_o,
    output logic [4:0]        ex_shamt_o,
    output logic [4:0]        ex_rs_o,
    output logic [4:0]        ex_rt_o,
    output logic [4:0]        ex_dst_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    ctrl_t            w_id_ctrl;
    logic [4:0]       w_rs;
    logic [4:0]       w_rt;
    logic [4:0]       w_rd;
    logic [XLEN-1:0]  w_imm;
    logic             w_hazard;
    logic             unused_opcode;

    logic             ex_valid_q,   ex_valid_d;
    ctrl_t            ex_ctrl_q,    ex_ctrl_d;
    logic [XLEN-1:0]  ex_pc_q,      ex_pc_d;
    logic [XLEN-1:0]  ex_a_q,       ex_a_d;
    logic [XLEN-1:0]  ex_b_q,       ex_b_d;
    logic [XLEN-1:0]  ex_imm_q,     ex_imm_d;
    logic [4:0]       ex_shamt_q,   ex_shamt_d;
    logic [4:0]       ex_rs_q,      ex_rs_d;
    logic [4:0]       ex_rt_q,      ex_rt_d;
    logic [4:0]       ex_dst_q,     ex_dst_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    assign w_id_ctrl     = ctrl_t'(id_ctrl_i);
    assign w_rs          = id_instr_i[25:21];
    assign w_rt          = id_instr_i[20:16];
    assign w_rd          = id_instr_i[15:11];
    assign unused_opcode = &{1'b0, id_instr_i[31:26]};
    assign w_imm         = w_id_ctrl.sext ? {{(XLEN-16){id_instr_i[15]}}, id_instr_i[15:0]}
                                          : {{(XLEN-16){1'b0}},           id_instr_i[15:0]};

    hazard_detect u_hazard_detect (
        .id_valid_i     (id_valid_i),
        .id_shift_i     (w_id_ctrl.shift),
        .id_link_i      (w_id_ctrl.link),
        .id_alu_imm_i   (w_id_ctrl.alu_imm),
        .id_mem_write_i (w_id_ctrl.mem_write),
        .id_rs_i        (w_rs),
        .id_rt_i        (w_rt),
        .ex_valid_i     (ex_valid_q),
        .ex_mem_read_i  (ex_ctrl_q.mem_read),
        .ex_dst_i       (ex_dst_q),
        .hazard_o       (w_hazard)
    );

    // A flush kills the ID instruction, so it never needs to wait.
    assign id_stall_o = !flush_i && (hold_i || w_hazard);

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_ctrl_d    = ex_ctrl_q;
        ex_pc_d      = ex_pc_q;
        ex_a_d       = ex_a_q;
        ex_b_d       = ex_b_q;
        ex_imm_d     = ex_imm_q;
        ex_shamt_d   = ex_shamt_q;
        ex_rs_d      = ex_rs_q;
        ex_rt_d      = ex_rt_q;
        ex_dst_d     = ex_dst_q;
        bubble_cnt_d = bubble_cnt_q;

        if (flush_i || (!hold_i && w_hazard)) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = CTRL_BUBBLE;
            ex_pc_d    = '0;
            ex_a_d     = '0;
            ex_b_d     = '0;
            ex_imm_d   = '0;
            ex_shamt_d = '0;
            ex_rs_d    = '0;
            ex_rt_d    = '0;
            ex_dst_d   = '0;
            if (!flush_i && (bubble_cnt_q != {CNT_W{1'b1}})) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end else if (!hold_i) begin
            ex_valid_d = id_valid_i;
            ex_ctrl_d  = id_valid_i ? w_id_ctrl : CTRL_BUBBLE;
            ex_pc_d    = id_pc_i;
            ex_a_d     = id_rs_val_i;
            ex_b_d     = id_rt_val_i;
            ex_imm_d   = w_imm;
            ex_shamt_d = id_instr_i[10:6];
            ex_rs_d    = w_rs;
            ex_rt_d    = w_rt;
            ex_dst_d   = id_valid_i ? dst_decode(w_id_ctrl.wb_sel, w_rt, w_rd) : 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q   <= 1'b0;
            ex_ctrl_q    <= CTRL_BUBBLE;
            ex_pc_q      <= '0;
            ex_a_q       <= '0;
            ex_b_q       <= '0;
            ex_imm_q     <= '0;
            ex_shamt_q   <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_dst_q     <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_ctrl_q    <= ex_ctrl_d;
            ex_pc_q      <= ex_pc_d;
            ex_a_q       <= ex_a_d;
            ex_b_q       <= ex_b_d;
            ex_imm_q     <= ex_imm_d;
            ex_shamt_q   <= ex_shamt_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_dst_q     <= ex_dst_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_valid_o   = ex_valid_q;
    assign ex_ctrl_o    = ex_ctrl_q;
    assign ex_pc_o      = ex_pc_q;
    assign ex_a_o       = ex_a_q;
    assign ex_b_o       = ex_b_q;
    assign ex_imm_o     = ex_imm_q;
    assign ex_shamt_o   = ex_shamt_q;
    assign ex_rs_o      = ex_rs_q;
    assign ex_rt_o      = ex_rt_q;
    assign ex_dst_o     = ex_dst_q;
    assign bubble_cnt_o = bubble_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Directed and randomized bench for id_ex_stage against a
//                behavioural model of the ID/EX register.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

    localparam int C_XLEN  = 32;
    localparam int C_CNT_W = 4;   // narrow counter so saturation is reachable

    // {wb_sel, sext, link, mem_to_reg, shift, alu_imm, alu_op, mem_write, mem_read}
    localparam logic [12:0] C_LW   = {2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1};
    localparam logic [12:0] C_ADD  = {2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0};
    localparam logic [12:0] C_SLL  = {2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0};
    localparam logic [12:0] C_ADDI = {2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0};
    localparam logic [12:0] C_ANDI = {2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0};
    localparam logic [12:0] C_JAL  = {2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};

    logic               clk = 1'b0;
    logic               reset;
    logic               id_valid_i;
    logic [12:0]        id_ctrl_i;
    logic [31:0]        id_instr_i;
    logic [C_XLEN-1:0]  id_pc_i;
    logic [C_XLEN-1:0]  id_rs_val_i;
    logic [C_XLEN-1:0]  id_rt_val_i;
    logic               hold_i;
    logic               flush_i;
    logic               id_stall_o;
    logic               ex_valid_o;
    logic [12:0]        ex_ctrl_o;
    logic [C_XLEN-1:0]  ex_pc_o;
    logic [C_XLEN-1:0]  ex_a_o;
    logic [C_XLEN-1:0]  ex_b_o;
    logic [C_XLEN-1:0]  ex_imm_o;
    logic [4:0]         ex_shamt_o;
    logic [4:0]         ex_rs_o;
    logic [4:0]         ex_rt_o;
    logic [4:0]         ex_dst_o;
    logic [C_CNT_W-1:0] bubble_cnt_o;

    int checks = 0;
    int errors = 0;
    logic obs_stall;

    // Behavioural view of what the EX register should hold.
    logic        m_valid;
    logic [12:0] m_ctrl;
    logic [31:0] m_pc, m_a, m_b, m_imm;
    logic [4:0]  m_shamt, m_rs, m_rt, m_dst;
    int          m_cnt;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(C_XLEN), .CNT_W(C_CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid_i   (id_valid_i),
        .id_ctrl_i    (id_ctrl_i),
        .id_instr_i   (id_instr_i),
        .id_pc_i      (id_pc_i),
        .id_rs_val_i  (id_rs_val_i),
        .id_rt_val_i  (id_rt_val_i),
        .hold_i       (hold_i),
        .flush_i      (flush_i),
        .id_stall_o   (id_stall_o),
        .ex_valid_o   (ex_valid_o),
        .ex_ctrl_o    (ex_ctrl_o),
        .ex_pc_o      (ex_pc_o),
        .ex_a_o       (ex_a_o),
        .ex_b_o       (ex_b_o),
        .ex_imm_o     (ex_imm_o),
        .ex_shamt_o   (ex_shamt_o),
        .ex_rs_o      (ex_rs_o),
        .ex_rt_o      (ex_rt_o),
        .ex_dst_o     (ex_dst_o),
        .bubble_cnt_o (bubble_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [15:0] imm);
        mk = {6'h00, rs, rt, imm};
    endfunction

    function automatic logic model_hazard(input logic v, input logic [12:0] c,
                                          input logic [31:0] ins);
        logic reads_rs, reads_rt;
        reads_rs = (c[7] == 1'b0) && (c[9] == 1'b0);
        reads_rt = (c[6] == 1'b0) || (c[1] == 1'b1);
        return m_valid && m_ctrl[0] && (m_dst != 0) && v &&
               ((reads_rs && ins[25:21] == m_dst) || (reads_rt && ins[20:16] == m_dst));
    endfunction

    task automatic bubble_model();
        m_valid = 0; m_ctrl = 0; m_pc = 0; m_a = 0; m_b = 0; m_imm = 0;
        m_shamt = 0; m_rs = 0; m_rt = 0; m_dst = 0;
    endtask

    // One clock: drive ID, check stall, clock, update model, compare EX.
    task automatic step(input logic v, input logic [12:0] c, input logic [31:0] ins,
                        input logic [31:0] pc, input logic [31:0] ra, input logic [31:0] rb,
                        input logic h, input logic f, input logic r);
        logic hz;
        id_valid_i = v; id_ctrl_i = c; id_instr_i = ins; id_pc_i = pc;
        id_rs_val_i = ra; id_rt_val_i = rb; hold_i = h; flush_i = f; reset = r;
        hz = model_hazard(v, c, ins);
        #1;
        obs_stall = id_stall_o;
        check("stall", {31'd0, obs_stall}, {31'd0, !f && (h || hz)});
        @(posedge clk);
        #1;
        if (r) begin
            bubble_model();
            m_cnt = 0;
        end else if (f) begin
            bubble_model();
        end else if (h) begin
            // EX frozen
        end else if (hz) begin
            bubble_model();
            if (m_cnt < (1 << C_CNT_W) - 1) m_cnt = m_cnt + 1;
        end else begin
            m_valid = v;
            m_ctrl  = v ? c : 13'd0;
            m_pc    = pc;
            m_a     = ra;
            m_b     = rb;
            m_imm   = c[10] ? {{16{ins[15]}}, ins[15:0]} : {16'd0, ins[15:0]};
            m_shamt = ins[10:6];
            m_rs    = ins[25:21];
            m_rt    = ins[20:16];
            if (!v)                    m_dst = 0;
            else if (c[12:11] == 2'b10) m_dst = ins[15:11];
            else if (c[12:11] == 2'b11) m_dst = ins[20:16];
            else if (c[12:11] == 2'b01) m_dst = 5'd31;
            else                        m_dst = 0;
        end
        check("valid", {31'd0, ex_valid_o}, {31'd0, m_valid});
        check("ctrl",  {19'd0, ex_ctrl_o},  {19'd0, m_ctrl});
        check("pc",    ex_pc_o,  m_pc);
        check("a",     ex_a_o,   m_a);
        check("b",     ex_b_o,   m_b);
        check("imm",   ex_imm_o, m_imm);
        check("shamt", {27'd0, ex_shamt_o}, {27'd0, m_shamt});
        check("rs",    {27'd0, ex_rs_o},    {27'd0, m_rs});
        check("rt",    {27'd0, ex_rt_o},    {27'd0, m_rt});
        check("dst",   {27'd0, ex_dst_o},   {27'd0, m_dst});
        check("cnt",   {28'd0, bubble_cnt_o}, m_cnt);
    endtask

    initial begin
        logic [31:0] lw8, add10;
        logic [31:0] ri;
        logic [12:0] rc;
        bubble_model();
        m_cnt = 0;
        lw8   = mk(5'd9, 5'd8, 16'h0000);
        add10 = {6'h00, 5'd8, 5'd11, 5'd10, 5'd0, 6'h20};

        // Reset with random inputs on the pins.
        repeat (2) step($urandom_range(0, 1), 13'($urandom), $urandom, $urandom, $urandom,
                        $urandom, $urandom_range(0, 1), $urandom_range(0, 1), 1'b1);
        id_valid_i = 0; hold_i = 0; flush_i = 0; reset = 0;
        #1;
        check("rst_stall", {31'd0, id_stall_o}, 32'd0);
        check("rst_valid", {31'd0, ex_valid_o}, 32'd0);
        check("rst_dst",   {27'd0, ex_dst_o},   32'd0);
        check("rst_cnt",   {28'd0, bubble_cnt_o}, 32'd0);
        @(negedge clk);
        @(posedge clk);

        // Load-use: lw $8 then add $10,$8,$11.
        step(1, C_LW,  lw8,   32'h400004, 32'h100, 32'h0, 0, 0, 0);
        step(1, C_ADD, add10, 32'h400008, 32'h5,   32'h6, 0, 0, 0);
        check("lu_stall",  {31'd0, obs_stall},  32'd1);
        check("lu_bubble", {31'd0, ex_valid_o}, 32'd0);
        check("lu_cnt",    {28'd0, bubble_cnt_o}, 32'd1);
        step(1, C_ADD, add10, 32'h400008, 32'h5,   32'h6, 0, 0, 0);
        check("lu_nostall", {31'd0, obs_stall}, 32'd0);
        check("lu_add_dst", {27'd0, ex_dst_o},  32'd10);

        // No false hazards.
        step(1, C_LW,   mk(5'd9, 5'd0, 16'h4), 32'h40000C, 0, 0, 0, 0, 0);
        step(1, C_ADD,  32'h00000020,          32'h400010, 0, 0, 0, 0, 0);
        check("nf_zero", {31'd0, obs_stall}, 32'd0);
        step(1, C_LW,   lw8,                   32'h400014, 0, 0, 0, 0, 0);
        step(1, C_SLL,  {6'h00, 5'd8, 5'd11, 5'd10, 5'd2, 6'h00}, 32'h400018, 0, 0, 0, 0, 0);
        check("nf_sll", {31'd0, obs_stall}, 32'd0);
        step(1, C_LW,   lw8,                   32'h40001C, 0, 0, 0, 0, 0);
        step(1, C_ADDI, mk(5'd12, 5'd9, 16'h5), 32'h400020, 0, 0, 0, 0, 0);
        check("nf_addi", {31'd0, obs_stall}, 32'd0);
        check("nf_cnt",  {28'd0, bubble_cnt_o}, 32'd1);

        // Flush together with a hazard.
        step(1, C_LW,  lw8,   32'h400024, 0, 0, 0, 0, 0);
        step(1, C_ADD, add10, 32'h400028, 0, 0, 0, 1, 0);
        check("fl_stall", {31'd0, obs_stall},  32'd0);
        check("fl_valid", {31'd0, ex_valid_o}, 32'd0);
        check("fl_cnt",   {28'd0, bubble_cnt_o}, 32'd1);

        // Hold for three cycles during a hazard.
        step(1, C_LW,  lw8,   32'h40002C, 32'h77, 0, 0, 0, 0);
        repeat (3) begin
            step(1, C_ADD, add10, 32'h400030, 0, 0, 1, 0, 0);
            check("hd_stall", {31'd0, obs_stall}, 32'd1);
            check("hd_dst",   {27'd0, ex_dst_o},  32'd8);
            check("hd_cnt",   {28'd0, bubble_cnt_o}, 32'd1);
        end
        step(1, C_ADD, add10, 32'h400030, 0, 0, 0, 0, 0);
        check("hd_bubble", {31'd0, ex_valid_o}, 32'd0);
        check("hd_cnt2",   {28'd0, bubble_cnt_o}, 32'd2);
        step(1, C_ADD, add10, 32'h400030, 0, 0, 0, 0, 0);
        check("hd_add", {27'd0, ex_dst_o}, 32'd10);

        // Decode corner cases.
        step(1, C_JAL,  32'h0C100000,           32'h00400010, 0, 0, 0, 0, 0);
        check("jal_dst", {27'd0, ex_dst_o}, 32'd31);
        check("jal_pc",  ex_pc_o, 32'h00400010);
        step(1, C_ANDI, mk(5'd1, 5'd2, 16'h8000), 32'h400014, 0, 0, 0, 0, 0);
        check("andi_imm", ex_imm_o, 32'h00008000);
        step(1, C_ADDI, mk(5'd1, 5'd2, 16'h8000), 32'h400018, 0, 0, 0, 0, 0);
        check("addi_imm", ex_imm_o, 32'hFFFF8000);

        // Randomized traffic with small register indices to provoke hazards.
        for (int i = 0; i < 800; i++) begin
            ri = $urandom;
            ri[25:21] = 5'($urandom_range(0, 3));
            ri[20:16] = 5'($urandom_range(0, 3));
            ri[15:11] = 5'($urandom_range(0, 3));
            rc = 13'($urandom);
            step($urandom_range(0, 9) < 8, rc, ri, $urandom, $urandom, $urandom,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 39) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
